// File: rtl/adc_sample_indexer.sv
// ADC sample indexer: tags each valid ADC sample with its index inside a triggered frame.
// Optional macro ADC_SAMPLE_INDEXER_AUTO_REARM_EN: DONE returns to ARMED instead of IDLE.
module adc_sample_indexer #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned IDX_W     = 16,
  parameter int unsigned FRAME_LEN = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              trigger,
  input  logic              abort,
  output logic [DATA_W-1:0] sample_value,
  output logic [IDX_W-1:0]  sample_index,
  output logic              sample_valid,
  output logic              start_beamformer,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  // cnt is one bit wider than the index so FRAME_LEN = 2^IDX_W fits.
  localparam logic [IDX_W:0] LastIdx = (IDX_W + 1)'(FRAME_LEN - 1);

  state_e             state_q, state_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic               capture;

  logic [DATA_W-1:0]  sample_value_q, sample_value_d;
  logic [IDX_W-1:0]   sample_index_q, sample_index_d;
  logic               sample_valid_q, sample_valid_d;
  logic               start_bf_q, start_bf_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;

  // A sample is taken in RUN, or in the ARMED cycle that accepts the trigger.
  assign capture = !abort && adc_valid &&
                   ((state_q == StRun) || ((state_q == StArmed) && trigger));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (arm) state_d = StArmed;
        end
        StArmed: begin
          if (trigger) begin
            state_d = StRun;
            cnt_d   = (IDX_W + 1)'(adc_valid);
            if (adc_valid && (LastIdx == '0)) state_d = StDone;
          end
        end
        StRun: begin
          if (adc_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastIdx) state_d = StDone;
          end
        end
        StDone: begin
          cnt_d = '0;
`ifdef ADC_SAMPLE_INDEXER_AUTO_REARM_EN
          state_d = StArmed;
`else
          state_d = StIdle;
`endif
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the captured sample.
  always_comb begin
    sample_value_d = sample_value_q;
    sample_index_d = sample_index_q;
    sample_valid_d = capture;
    if (capture) begin
      sample_value_d = adc_data;
      sample_index_d = cnt_q[IDX_W-1:0];
    end
    start_bf_d   = (state_d == StRun) || (state_d == StDone);
    frame_done_d = (state_d == StDone);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_value_q <= '0;
      sample_index_q <= '0;
      sample_valid_q <= 1'b0;
      start_bf_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sample_value_q <= sample_value_d;
      sample_index_q <= sample_index_d;
      sample_valid_q <= sample_valid_d;
      start_bf_q     <= start_bf_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
    end
  end

  assign sample_value     = sample_value_q;
  assign sample_index     = sample_index_q;
  assign sample_valid     = sample_valid_q;
  assign start_beamformer = start_bf_q;
  assign frame_done       = frame_done_q;
  assign busy             = busy_q;

endmodule

// File: doc/adc_sample_indexer.md
# adc_sample_indexer

- Upstream feeder for the delay beamformer.
- Takes a raw 12-bit ADC sample stream qualified by a valid strobe and counts samples from a trigger.
- Presents each sample with its 16-bit sample index and holds the beamformer's start enable for exactly one acquisition frame of FRAME_LEN samples.
- Moves sample index generation out of the beamformer; the beamformer only compares the presented index against its delay table.

## Interface
- DATA_W, 12, ADC sample width.
- IDX_W, 16, sample index width.
- FRAME_LEN, 4096, samples per acquisition. Legal range is 1..2^IDX_W.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock domain, async assert.
- adc_data  input  DATA_W  raw ADC sample.
- adc_valid  input  1  adc_data valid this cycle; no backpressure.
- arm  input  1  level/pulse; arms the block from IDLE.
- trigger  input  1  starts acquisition when ARMED.
- abort  input  1  synchronous abort; highest priority.
- sample_value  output  DATA_W  registered sample; feeds beamformer input_value.
- sample_index  output  IDX_W  index of sample_value; feeds beamformer input_index.
- sample_valid  output  1  sample_value/sample_index updated this cycle.
- start_beamformer  output  1  beamformer enable; high for the whole frame.
- frame_done  output  1  one-cycle pulse after the last sample of a frame.
- busy  output  1  high in ARMED, RUN, DONE.

## Operation
- States: IDLE, ARMED, RUN, DONE. Internal counter cnt is IDX_W+1 bits wide so FRAME_LEN=2^IDX_W is representable.
- IDLE:
  - arm goes to ARMED.
  - trigger is ignored in IDLE, including when it arrives in the same cycle as arm.
- ARMED, on trigger:
  - Go to RUN with cnt=0.
  - If adc_valid is asserted in the trigger cycle, that sample is index 0 and cnt=1.
  - If FRAME_LEN=1 and that sample is captured, go directly to DONE.
- RUN, on each adc_valid:
  - Capture sample_value=adc_data and sample_index=cnt[IDX_W-1:0], then cnt=cnt+1.
  - When the captured index equals FRAME_LEN-1, go to DONE.
- DONE:
  - Lasts exactly one cycle; frame_done=1.
  - adc_valid in DONE is dropped.
  - Next state is IDLE (see Configuration).
- abort in any state:
  - Go to IDLE, clear cnt, suppress capture in that cycle.
  - No frame_done; arm and trigger are ignored in the abort cycle.
- Samples outside RUN and the ARMED trigger cycle are never presented.
- Between samples, sample_value and sample_index hold their last value and sample_valid=0.
- Index is never reused within a frame. Indices run 0..FRAME_LEN-1 contiguous in arrival order regardless of gaps in adc_valid.

## Timing
- Reset values: sample_value=0, sample_index=0, sample_valid=0, start_beamformer=0, frame_done=0, busy=0; state=IDLE, cnt=0.
- Latency: adc_data/adc_valid at edge N appear on sample_value/sample_valid after edge N+1, i.e. 1 cycle. All outputs are registered.
- start_beamformer rises in the same cycle as the first RUN-state output cycle, one cycle after trigger is accepted.
  - It stays high through the DONE cycle, so the last sample (presented in DONE) is qualified.
  - It falls on the edge leaving DONE, or one cycle after abort.
- frame_done coincides with the sample_valid of index FRAME_LEN-1.
- busy rises the cycle after arm is accepted and falls the cycle after DONE or abort.
- Reset asserted mid-frame clears all outputs immediately; on release the block is in IDLE.

## Configuration
- ADC_SAMPLE_INDEXER_AUTO_REARM_EN defined: DONE goes to ARMED, so the next trigger starts a new frame without a new arm. abort still returns to IDLE.
- Not defined: DONE goes to IDLE and a new arm is required. A trigger in the DONE cycle is ignored either way.

## Test plan
- FRAME_LEN=8, continuous adc_valid with adc_data=0x100+k:
  - arm, then trigger two cycles later.
  - Expect indices 0..7, values 0x100..0x107, start_beamformer high for exactly 8 cycles, and frame_done on the index-7 cycle.
- FRAME_LEN=8, adc_valid on alternate cycles: indices stay contiguous 0..7, sample_valid shows a 1-0 pattern, and indices hold between valid pulses.
- trigger and adc_valid in the same cycle while ARMED with adc_data=0xABC: first output is index 0 = 0xABC one cycle later.
- trigger in IDLE and trigger together with arm: no sample_valid, start_beamformer stays 0, state ends ARMED after the arm cycle.
- abort after index 3 is presented: next cycle start_beamformer=0, busy=0, no frame_done; a new arm plus trigger restarts at index 0.
- FRAME_LEN=1 and FRAME_LEN=65536 (spot check): index 0 presented with frame_done in the same cycle; the final index is 0xFFFF with no wrap before DONE.
  - Repeat with the macro defined: a second trigger without arm produces a new frame.
  - Repeat with the macro undefined: the second trigger is ignored.
  - rst_n pulsed mid-frame: all outputs are 0 during reset and the block is in IDLE after release.
